// File: rtl/run_timer_alarm.sv
// Run-time minutes:seconds counter with programmable alarm and tone-driven buzzer.
// Feeds the display mux (run_min/run_sec) and the buzzer pin (beep).
module run_timer_alarm #(
   parameter int MIN_W     = 8,
   parameter int MAX_MIN   = 99,
   parameter int WRAP      = 0,
   parameter int BEEP_SECS = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_1Hz,
   input  logic             tone_tick,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             alarm_en,
   input  logic [MIN_W-1:0] alarm_min,
   input  logic [5:0]       alarm_sec,
   input  logic             alarm_ack,
   output logic [MIN_W-1:0] run_min,
   output logic [5:0]       run_sec,
   output logic             running,
   output logic             ringing,
   output logic             overflow,
   output logic             beep
);

   typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_e;

   localparam logic [MIN_W-1:0] MAX_M   = MIN_W'(MAX_MIN);
   localparam logic [7:0]       BEEP_LD = 8'(BEEP_SECS);

   state_e           state_q, state_d;
   logic [MIN_W-1:0] min_q, min_d;
   logic [5:0]       sec_q, sec_d;
   logic             ovf_q, ovf_d;
   logic             adv_q, adv_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             ring_q, ring_d;
   logic             beep_q, beep_d;
   logic             tick_s;
   logic             hit_s;

   // Next-state logic for counter, FSM, alarm ring and buzzer
   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      ovf_d   = ovf_q;
      adv_d   = 1'b0;
      cnt_d   = cnt_q;
      ring_d  = ring_q;
      tick_s  = (state_q == ST_RUN) && clk_1Hz && !clear && !stop;
      hit_s   = adv_q && alarm_en && (min_q == alarm_min) && (sec_q == alarm_sec);

      if (clear) begin
         min_d = '0;
         sec_d = 6'd0;
         ovf_d = 1'b0;
      end else if (stop) begin
         state_d = ST_STOP;
      end else if (tick_s) begin
         if (sec_q < 6'd59) begin
            sec_d = sec_q + 6'd1;
            adv_d = 1'b1;
         end else if (min_q != MAX_M) begin
            sec_d = 6'd0;
            min_d = min_q + MIN_W'(1);
            adv_d = 1'b1;
         end else if (WRAP != 0) begin
            sec_d = 6'd0;
            min_d = '0;
            adv_d = 1'b1;
         end else begin
            // saturate: hold MAX_MIN:59 without advancing so the alarm cannot re-match
            ovf_d   = 1'b1;
            state_d = ST_STOP;
         end
      end else if (start && !ovf_q) begin
         state_d = ST_RUN;
      end else begin
         state_d = state_q;
      end

      if (clear || alarm_ack) begin
         ring_d = 1'b0;
         cnt_d  = 8'd0;
      end else if (hit_s) begin
         ring_d = 1'b1;
         cnt_d  = BEEP_LD;
      end else if (ring_q) begin
         if (cnt_q == 8'd0) begin
            ring_d = 1'b0;
         end else if (clk_1Hz) begin
            cnt_d = cnt_q - 8'd1;
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         ring_d = 1'b0;
      end

      // beep drops in the same cycle ringing does, and never starts high
      if (ring_q && ring_d) begin
         beep_d = beep_q ^ tone_tick;
      end else begin
         beep_d = 1'b0;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_STOP;
         min_q   <= '0;
         sec_q   <= 6'd0;
         ovf_q   <= 1'b0;
         adv_q   <= 1'b0;
         cnt_q   <= 8'd0;
         ring_q  <= 1'b0;
         beep_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         ovf_q   <= ovf_d;
         adv_q   <= adv_d;
         cnt_q   <= cnt_d;
         ring_q  <= ring_d;
         beep_q  <= beep_d;
      end
   end

   assign run_min  = min_q;
   assign run_sec  = sec_q;
   assign running  = (state_q == ST_RUN);
   assign ringing  = ring_q;
   assign overflow = ovf_q;
   assign beep     = beep_q;

endmodule
